// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg: shared types and defaults for the clock-divider scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clkdiv_pkg;

  localparam int LIM_W = 8;
  localparam logic [LIM_W-1:0] DEF_LIM = 8'd4;

  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_RUN      = 2'd1,
    CH_RUN_PEND = 2'd2
  } chan_state_t;

  typedef struct packed {
    logic [LIM_W-1:0] lim;
    logic             en;
  } div_cfg_t;

endpackage

`default_nettype wire

// File: rtl/clkdiv_chan.sv
// ---------------------------------------------------------------------------
// clkdiv_chan: one divider channel; new settings take effect on a period boundary
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clkdiv_chan #(
  parameter int                BITLEN  = clkdiv_pkg::LIM_W,
  parameter logic [BITLEN-1:0] DEF_LIM = clkdiv_pkg::DEF_LIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [BITLEN-1:0] cfg_lim,
  input  logic              cfg_en,
  output logic              hz,
  output logic              tick,
  output logic              pend
);

  import clkdiv_pkg::*;

  localparam logic [1:0] ST_IDLE     = CH_IDLE;
  localparam logic [1:0] ST_RUN      = CH_RUN;
  localparam logic [1:0] ST_RUN_PEND = CH_RUN_PEND;

  logic [1:0]        state_q,   state_d;
  logic [BITLEN-1:0] cnt_q,     cnt_d;
  logic [BITLEN-1:0] lim_act_q, lim_act_d;
  div_cfg_t          shadow_q,  shadow_d;
  logic              hz_q,      hz_d;
  logic              tick_q,    tick_d;
  logic              pend_q,    pend_d;
  logic              terminal;

  assign terminal = (cnt_q == lim_act_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lim_act_d = lim_act_q;
    shadow_d  = shadow_q;
    hz_d      = hz_q;
    tick_d    = 1'b0;
    pend_d    = pend_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cfg_we) begin
          lim_act_d = cfg_lim;
          state_d   = cfg_en ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        if (terminal) begin
          cnt_d  = '0;
          hz_d   = ~hz_q;
          tick_d = 1'b1;
          // A write landing on the boundary itself needs no shadowing.
          if (cfg_we) begin
            lim_act_d = cfg_lim;
            state_d   = cfg_en ? ST_RUN : ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cfg_we) begin
            shadow_d = '{lim: cfg_lim, en: cfg_en};
            pend_d   = 1'b1;
            state_d  = ST_RUN_PEND;
          end
        end
      end
      ST_RUN_PEND: begin
        if (terminal) begin
          cnt_d     = '0;
          hz_d      = ~hz_q;
          tick_d    = 1'b1;
          lim_act_d = shadow_q.lim;
          pend_d    = 1'b0;
          state_d   = shadow_q.en ? ST_RUN : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      lim_act_q <= DEF_LIM;
      shadow_q  <= '0;
      hz_q      <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lim_act_q <= lim_act_d;
      shadow_q  <= shadow_d;
      hz_q      <= hz_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
    end
  end

  assign hz   = hz_q;
  assign tick = tick_q;
  assign pend = pend_q;

endmodule

`default_nettype wire

// File: rtl/clkdiv_sched.sv
// ---------------------------------------------------------------------------
// clkdiv_sched: NCH independent clock dividers behind one valid/ready config port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clkdiv_sched #(
  parameter int                NCH     = 4,
  parameter int                BITLEN  = clkdiv_pkg::LIM_W,
  parameter logic [BITLEN-1:0] DEF_LIM = clkdiv_pkg::DEF_LIM
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [BITLEN-1:0]                     cfg_lim,
  input  logic                                  cfg_en,
  output logic [NCH-1:0]                        hz,
  output logic [NCH-1:0]                        tick,
  output logic [NCH-1:0]                        pend
);

  import clkdiv_pkg::*;

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  // The shadow register type is fixed-width in the package.
  if (BITLEN != LIM_W) begin : g_bitlen_chk
    $error("clkdiv_sched: BITLEN must equal clkdiv_pkg::LIM_W");
  end

  // Unmatched channel numbers leave cfg_ready high, so they are swallowed.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic cfg_we;
    assign cfg_we = cfg_valid && (cfg_ch == CH_W'(g)) && !pend[g];

    clkdiv_chan #(
      .BITLEN  (BITLEN),
      .DEF_LIM (DEF_LIM)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .cfg_we  (cfg_we),
      .cfg_lim (cfg_lim),
      .cfg_en  (cfg_en),
      .hz      (hz[g]),
      .tick    (tick[g]),
      .pend    (pend[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_sched.sv
// ---------------------------------------------------------------------------
// tb_clkdiv_sched: directed self-checking bench for clkdiv_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clkdiv_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid, cfg_ready, cfg_en;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_lim;
  logic [3:0] hz, tick, pend;

  logic       cfg_valid3, cfg_ready3;
  logic [1:0] cfg_ch3;
  logic [2:0] hz3, tick3, pend3;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  clkdiv_sched #(.NCH(4), .BITLEN(8), .DEF_LIM(8'd4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_lim   (cfg_lim),
    .cfg_en    (cfg_en),
    .hz        (hz),
    .tick      (tick),
    .pend      (pend)
  );

  // Three-channel instance so that an out-of-range channel number exists.
  clkdiv_sched #(.NCH(3), .BITLEN(8), .DEF_LIM(8'd4)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_lim   (cfg_lim),
    .cfg_en    (cfg_en),
    .hz        (hz3),
    .tick      (tick3),
    .pend      (pend3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_valid3 = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
  endtask

  task automatic run_to(input int k);
    while (edge_n < k) begin
      @(negedge clk);
      edge_n++;
    end
  endtask

  task automatic cfg_put(input logic [1:0] ch, input logic [7:0] lim, input logic en);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_lim   = lim;
    cfg_en    = en;
  endtask

  initial begin
    cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_lim = 8'd0; cfg_en = 1'b0;
    cfg_valid3 = 1'b0; cfg_ch3 = 2'd0;

    // 1: defaults, plus an always-valid out-of-range write on the 3-channel instance
    do_reset();
    chk("rst_hz",    32'(hz),        32'h0);
    chk("rst_tick",  32'(tick),      32'h0);
    chk("rst_pend",  32'(pend),      32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_lim = 8'd0; cfg_en = 1'b0;
    chk("oor_ready", 32'(cfg_ready3), 32'h1);
    for (int n = 1; n <= 10; n++) begin
      run_to(n);
      chk("t1_hz",   32'(hz),   (n >= 5 && n < 10) ? 32'hF : 32'h0);
      chk("t1_tick", 32'(tick), (n == 5 || n == 10) ? 32'hF : 32'h0);
    end
    chk("oor_pend", 32'(pend3), 32'h0);
    run_to(5 + 10);
    chk("oor_hz", 32'(hz3), 32'h7);

    // 2: ch1 retimed to lim=2 mid-period
    do_reset();
    run_to(2);
    cfg_put(2'd1, 8'd2, 1'b1);
    chk("t2_ready_pre", 32'(cfg_ready), 32'h1);
    run_to(3);
    cfg_valid = 1'b0;
    chk("t2_pend",    32'(pend),      32'h2);
    chk("t2_ready_b", 32'(cfg_ready), 32'h0);
    run_to(4);  chk("t2_pend4", 32'(pend), 32'h2);
    run_to(5);
    chk("t2_pend5", 32'(pend), 32'h0);
    chk("t2_hz5",   32'(hz),   32'hF);
    run_to(8);
    chk("t2_hz8",   32'(hz),   32'hD);
    chk("t2_tick8", 32'(tick), 32'h2);
    run_to(10);
    chk("t2_hz10",   32'(hz),   32'h0);
    chk("t2_tick10", 32'(tick), 32'hD);
    run_to(11);
    chk("t2_hz11",   32'(hz),   32'h2);
    chk("t2_tick11", 32'(tick), 32'h2);

    // 3: ch0 disabled at its boundary, then restarted at lim=0
    do_reset();
    run_to(1);
    cfg_put(2'd0, 8'd7, 1'b0);
    run_to(2);
    cfg_valid = 1'b0;
    chk("t3_pend", 32'(pend), 32'h1);
    run_to(5);
    chk("t3_hz5",   32'(hz),   32'hF);
    chk("t3_pend5", 32'(pend), 32'h0);
    run_to(10);
    chk("t3_hz10",   32'(hz),   32'h1);
    chk("t3_tick10", 32'(tick), 32'hE);
    cfg_put(2'd0, 8'd0, 1'b1);
    chk("t3_ready_idle", 32'(cfg_ready), 32'h1);
    run_to(11);
    cfg_valid = 1'b0;
    chk("t3_hz0_11",   32'(hz[0]),   32'h1);
    chk("t3_tick0_11", 32'(tick[0]), 32'h0);
    for (int n = 12; n <= 14; n++) begin
      run_to(n);
      chk("t3_hz0_fast",   32'(hz[0]),   (n % 2 == 0) ? 32'h0 : 32'h1);
      chk("t3_tick0_fast", 32'(tick[0]), 32'h1);
    end

    // 4: write to ch2 exactly on its terminal-count cycle
    do_reset();
    run_to(4);
    cfg_put(2'd2, 8'd1, 1'b1);
    chk("t4_ready", 32'(cfg_ready), 32'h1);
    run_to(5);
    cfg_valid = 1'b0;
    chk("t4_pend5", 32'(pend), 32'h0);
    chk("t4_hz5",   32'(hz),   32'hF);
    run_to(6);  chk("t4_pend6", 32'(pend), 32'h0);
    run_to(7);
    chk("t4_hz7",   32'(hz),   32'hB);
    chk("t4_tick7", 32'(tick), 32'h4);
    run_to(9);
    chk("t4_hz9",   32'(hz),   32'hF);
    chk("t4_tick9", 32'(tick), 32'h4);
    run_to(10);
    chk("t4_hz10",   32'(hz),   32'h4);
    chk("t4_tick10", 32'(tick), 32'hB);

    // 5: second write to a pending ch3 held until its boundary
    do_reset();
    run_to(1);
    cfg_put(2'd3, 8'd1, 1'b1);
    run_to(2);
    chk("t5_pend2", 32'(pend), 32'h8);
    cfg_lim = 8'd3;
    chk("t5_ready2", 32'(cfg_ready), 32'h0);
    run_to(4);  chk("t5_ready4", 32'(cfg_ready), 32'h0);
    run_to(5);
    chk("t5_pend5",  32'(pend),      32'h0);
    chk("t5_ready5", 32'(cfg_ready), 32'h1);
    chk("t5_hz5",    32'(hz),        32'hF);
    run_to(6);
    cfg_valid = 1'b0;
    chk("t5_pend6", 32'(pend), 32'h8);
    run_to(7);
    chk("t5_pend7", 32'(pend), 32'h0);
    chk("t5_hz7",   32'(hz),   32'h7);
    chk("t5_tick7", 32'(tick), 32'h8);
    run_to(10);
    chk("t5_hz10",   32'(hz),   32'h0);
    chk("t5_tick10", 32'(tick), 32'h7);
    run_to(11);
    chk("t5_hz11",   32'(hz),   32'h8);
    chk("t5_tick11", 32'(tick), 32'h8);

    // 6: asynchronous reset while ch3 holds a pending disable
    do_reset();
    run_to(6);
    cfg_put(2'd3, 8'd1, 1'b0);
    run_to(7);
    cfg_valid = 1'b0;
    chk("t6_pend_pre", 32'(pend), 32'h8);
    chk("t6_hz_pre",   32'(hz),   32'hF);
    #2 rst = 1'b1;
    #1;
    chk("t6_hz_async",   32'(hz),   32'h0);
    chk("t6_pend_async", 32'(pend), 32'h0);
    chk("t6_tick_async", 32'(tick), 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
    run_to(4);  chk("t6_hz4", 32'(hz), 32'h0);
    run_to(5);
    chk("t6_hz5",   32'(hz),   32'hF);
    chk("t6_tick5", 32'(tick), 32'hF);
    chk("t6_pend5", 32'(pend), 32'h0);
    run_to(10);
    chk("t6_hz10", 32'(hz), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
